ammo_hud_renderer: RTL
======================

// Module: ammo_hud_renderer
// PURPOSE
// - Stateful ammo HUD: owns the magazine count, grants fire requests, runs a frame-paced reload, and renders
//   MAX_AMMO bullet slots as an RGBA overlay layer.
// - Sits between game logic (fire/reload events, frame_tick) and the VGA compositor (x/y in, RGBA out).
// - Slot pixels come from the existing bullet_img sprite: combinational x,y -> R,G,B,A.
// PARAMETERS
// MAX_AMMO       5    number of slots / magazine size (1..15)
// SLOT_W         11   slot sprite width, px
// SLOT_H         32   slot sprite height, px
// SLOT_GAP       1    horizontal gap between slots, px
// ORIGIN_X       2    x of slot 0 left edge
// ORIGIN_Y       446  y of slot top edge
// RELOAD_FRAMES  30   frame_ticks per refilled round
// BLINK_FRAMES   16   frame_ticks per half-period of empty blink
// PORTS
// clk         in   1   pixel clock
// rst         in   1   synchronous active-high reset
// frame_tick  in   1   one-cycle pulse per frame (start of vblank)
// fire_req    in   1   one-cycle fire request
// reload_req  in   1   one-cycle reload request
// x, y        in   10  current pixel coordinate
// fire_ack    out  1   one-cycle pulse: shot granted
// ammo        out  CW  rounds in magazine, CW = $clog2(MAX_AMMO+1)
// reloading   out  1   high while in RELOAD state
// R, G, B     out  8   overlay colour, registered
// A           out  1   overlay alpha, registered
// BEHAVIOUR
// - Reset state (rst sampled on clk edge):
//   - ammo = MAX_AMMO, state READY, fire_ack = 0, reloading = 0.
//   - R/G/B = 0, A = 0; frame counter = 0, blink phase = 0.
// - States READY, RELOAD, EMPTY.
//   - fire_req with ammo>0, any state:
//     - ammo -= 1; fire_ack = 1 the next cycle, for exactly one cycle.
//     - Cancels RELOAD (frame counter cleared). Next state is READY, or EMPTY if the new ammo is 0.
//   - fire_req with ammo==0: no ack, no state change.
//   - reload_req with ammo<MAX_AMMO and no simultaneous grantable fire:
//     - Enter RELOAD, frame counter = 0.
//     - Ignored when ammo==MAX_AMMO or already in RELOAD.
//   - Simultaneous fire_req and reload_req: fire is evaluated first; reload is accepted only if the fire is not granted.
//   - RELOAD: frame counter increments on frame_tick. When it reaches RELOAD_FRAMES-1 on a tick:
//     - ammo += 1 and the counter clears.
//     - If ammo becomes MAX_AMMO, go to READY.
//   - EMPTY: blink phase toggles every BLINK_FRAMES frame_ticks. The phase clears on leaving EMPTY.
// - Render, 1-cycle latency: outputs at cycle n+1 reflect x,y and state sampled at cycle n.
//   - Slot i occupies x in [ORIGIN_X+i*(SLOT_W+SLOT_GAP), +SLOT_W) and y in [ORIGIN_Y, ORIGIN_Y+SLOT_H).
//   - Sprite coordinates are x-left edge and y-ORIGIN_Y, both 10-bit; slots never overlap.
//   - Slot i with i<ammo: sprite RGBA as-is.
//   - Slot i==ammo in RELOAD: sprite colour halved (each channel >>1), alpha as sprite.
//   - EMPTY with blink phase 1: every slot drawn FF,00,00 where sprite A=1.
//   - Otherwise, and outside all slots: 000000, A=0.
// - All arithmetic is unsigned. ammo never wraps: decrement is gated at 0, increment at MAX_AMMO.
// - rst mid-reload or mid-blink: the full reset state applies on the next cycle; no ack is issued.
// TESTING
// 1. Reset, then x=2,y=446 -> next cycle RGBA = bullet_img(0,0); ammo=5; reloading=0.
// 2. Six fire_req pulses, 3 cycles apart:
//    - five fire_ack pulses, ammo 4,3,2,1,0; sixth gets no ack.
//    - EMPTY; after 16 ticks, slot 2 pixel with sprite A=1 -> FF0000.
// 3. From ammo=0, reload_req, then 150 frame_ticks:
//    - ammo steps +1 every 30 ticks to 5; reloading drops with the 5th increment.
//    - slot==ammo is drawn at half colour meanwhile.
// 4. ammo=2 in RELOAD, fire_req and reload_req in the same cycle:
//    - fire_ack, ammo=1, READY, reloading=0, counter cleared.
// 5. ammo=5, reload_req -> ignored, reloading stays 0.
//    - x=100,y=446 (outside slots) -> A=0, RGB=0.
// 6. rst asserted at tick 17 of a reload -> ammo=5, READY, A=0 next cycle, no fire_ack.

Source files
------------

// File: rtl/ammo_hud_renderer.sv
// Ammo HUD: magazine count, fire/reload control with a frame-paced reload, and
// a registered RGBA overlay of MAX_AMMO bullet slots drawn from the bullet_img sprite.

module bullet_img (
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    output logic       o_a
);
    logic w_on;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_on = 1'b0;
        if (i_y < 10'd4)       w_on = (i_x >= 10'd4) && (i_x <= 10'd6);
        else if (i_y < 10'd8)  w_on = (i_x >= 10'd2) && (i_x <= 10'd8);
        else if (i_y < 10'd30) w_on = (i_x >= 10'd1) && (i_x <= 10'd9);
        else if (i_y < 10'd32) w_on = (i_x >= 10'd2) && (i_x <= 10'd8);
    end

    // Copper tip over the first 8 rows, brass case below; transparent pixels are black.
    always_comb begin
        o_a = w_on;
        o_r = 8'h00;
        o_g = 8'h00;
        o_b = 8'h00;
        if (w_on) begin
            if (i_y < 10'd8) begin
                o_r = 8'hB8; o_g = 8'h73; o_b = 8'h33;
            end else begin
                o_r = 8'hC8; o_g = 8'h96; o_b = 8'h32;
            end
        end
    end
endmodule

module ammo_hud_renderer #(
    parameter int MAX_AMMO      = 5,
    parameter int SLOT_W        = 11,
    parameter int SLOT_H        = 32,
    parameter int SLOT_GAP      = 1,
    parameter int ORIGIN_X      = 2,
    parameter int ORIGIN_Y      = 446,
    parameter int RELOAD_FRAMES = 30,
    parameter int BLINK_FRAMES  = 16,
    localparam int CW           = $clog2(MAX_AMMO + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_frame_tick,
    input  logic          i_fire_req,
    input  logic          i_reload_req,
    input  logic [9:0]    i_x,
    input  logic [9:0]    i_y,
    output logic          o_fire_ack,
    output logic [CW-1:0] o_ammo,
    output logic          o_reloading,
    output logic [7:0]    o_r,
    output logic [7:0]    o_g,
    output logic [7:0]    o_b,
    output logic          o_a
);
    localparam logic [1:0] ST_READY  = 2'd0;
    localparam logic [1:0] ST_RELOAD = 2'd1;
    localparam logic [1:0] ST_EMPTY  = 2'd2;

    localparam int PITCH = SLOT_W + SLOT_GAP;
    localparam int FMAX  = (RELOAD_FRAMES > BLINK_FRAMES) ? RELOAD_FRAMES : BLINK_FRAMES;
    localparam int FCW   = (FMAX > 1) ? $clog2(FMAX) : 1;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_ammo;
    logic [FCW-1:0] r_frame_cnt;
    logic           r_blink;
    logic           r_fire_ack;

    logic w_fire_grant;
    logic w_reload_acc;

    // Fire has priority; a granted shot suppresses a same-cycle reload.
    assign w_fire_grant = i_fire_req && (r_ammo != '0);
    assign w_reload_acc = i_reload_req && !w_fire_grant
                          && (r_ammo < CW'(MAX_AMMO)) && (r_state != ST_RELOAD);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_READY;
            r_ammo      <= CW'(MAX_AMMO);
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
            r_fire_ack  <= 1'b0;
        end else begin
            r_fire_ack <= w_fire_grant;
            if (w_fire_grant) begin
                r_ammo      <= r_ammo - CW'(1);
                r_frame_cnt <= '0;
                r_blink     <= 1'b0;
                r_state     <= (r_ammo == CW'(1)) ? ST_EMPTY : ST_READY;
            end else if (w_reload_acc) begin
                r_state     <= ST_RELOAD;
                r_frame_cnt <= '0;
                r_blink     <= 1'b0;
            end else if (i_frame_tick && r_state == ST_RELOAD) begin
                if (r_frame_cnt == FCW'(RELOAD_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    if (r_ammo < CW'(MAX_AMMO)) r_ammo <= r_ammo + CW'(1);
                    if (r_ammo + CW'(1) == CW'(MAX_AMMO)) r_state <= ST_READY;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FCW'(1);
                end
            end else if (i_frame_tick && r_state == ST_EMPTY) begin
                if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FCW'(1);
                end
            end
        end
    end

    logic       w_hit_x;
    logic       w_in_y;
    logic [3:0] w_idx;
    logic [9:0] w_sx;
    logic [9:0] w_sy;
    logic [7:0] w_sp_r, w_sp_g, w_sp_b;
    logic       w_sp_a;

    // Slots are disjoint, so at most one iteration can match.
    always_comb begin
        w_hit_x = 1'b0;
        w_idx   = '0;
        w_sx    = '0;
        for (int i = 0; i < MAX_AMMO; i++) begin
            if ({1'b0, i_x} >= 11'(ORIGIN_X + i * PITCH) &&
                {1'b0, i_x} <  11'(ORIGIN_X + i * PITCH + SLOT_W)) begin
                w_hit_x = 1'b1;
                w_idx   = 4'(i);
                w_sx    = i_x - 10'(ORIGIN_X + i * PITCH);
            end
        end
    end

    assign w_in_y = ({1'b0, i_y} >= 11'(ORIGIN_Y)) && ({1'b0, i_y} < 11'(ORIGIN_Y + SLOT_H));
    assign w_sy   = i_y - 10'(ORIGIN_Y);

    bullet_img u_sprite (
        .i_x (w_sx),
        .i_y (w_sy),
        .o_r (w_sp_r),
        .o_g (w_sp_g),
        .o_b (w_sp_b),
        .o_a (w_sp_a)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_r <= 8'h00;
            o_g <= 8'h00;
            o_b <= 8'h00;
            o_a <= 1'b0;
        end else begin
            o_r <= 8'h00;
            o_g <= 8'h00;
            o_b <= 8'h00;
            o_a <= 1'b0;
            if (w_hit_x && w_in_y) begin
                if (r_state == ST_EMPTY && r_blink) begin
                    o_a <= w_sp_a;
                    o_r <= w_sp_a ? 8'hFF : 8'h00;
                end else if (w_idx < 4'(r_ammo)) begin
                    o_r <= w_sp_r;
                    o_g <= w_sp_g;
                    o_b <= w_sp_b;
                    o_a <= w_sp_a;
                end else if (w_idx == 4'(r_ammo) && r_state == ST_RELOAD) begin
                    o_r <= w_sp_r >> 1;
                    o_g <= w_sp_g >> 1;
                    o_b <= w_sp_b >> 1;
                    o_a <= w_sp_a;
                end
            end
        end
    end

    assign o_fire_ack  = r_fire_ack;
    assign o_ammo      = r_ammo;
    assign o_reloading = (r_state == ST_RELOAD);
endmodule
